// File: rtl/perf_pkg.sv
// perf_pkg: shared FSM encoding and default event-channel indices for the perf counter bank
package perf_pkg;
    typedef enum logic [1:0] {COUNT, DUMP, DONE} state_e;
    localparam int CH_INST = 0;
    localparam int CH_IREQ = 1;
    localparam int CH_IHIT = 2;
    localparam int CH_DREQ = 3;
    localparam int CH_DHIT = 4;
endpackage

// File: rtl/perf_counter.sv
// perf_counter: one event counter with a sticky overflow flag, wrapping or saturating
module perf_counter #(
    parameter int CNT_W    = 32,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             wrap;
    always_comb begin
        wrap  = inc && (&cnt_q);
        cnt_d = clr ? '0 : !inc ? cnt_q : wrap ? (SATURATE ? cnt_q : '0) : cnt_q + CNT_W'(1);
        ovf_d = !clr && (ovf_q || wrap);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end
    assign cnt = cnt_q;
    assign ovf = ovf_q;
endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: event/cycle counters that freeze on halt and stream out over a valid/ready dump port
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_CH   = 5,
    parameter int CNT_W    = 32,
    parameter bit SATURATE = 1'b0,
    parameter int IDX_W    = $clog2(NUM_CH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [NUM_CH-1:0] event_i,
    input  logic              halt_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [IDX_W-1:0]  dump_idx_o,
    output logic [CNT_W-1:0]  dump_data_o,
    output logic              done_o,
    output logic [NUM_CH:0]   ovf_o,
    output logic [CNT_W-1:0]  cycle_cnt_o
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CH);
    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, nxt;
    logic [CNT_W-1:0] data_q, data_d, sel, first;
    logic [CNT_W-1:0] cnt [NUM_CH+1];
    logic [NUM_CH:0]  inc;
    logic             counting;
    assign counting = (state_q == COUNT) && en && !clr;
    assign inc      = counting ? {1'b1, event_i} : '0;
    for (genvar i = 0; i <= NUM_CH; i++) begin : g_cnt
        perf_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_cnt (
            .clk  (clk),
            .rst_n(rst_n),
            .clr  (clr),
            .inc  (inc[i]),
            .cnt  (cnt[i]),
            .ovf  (ovf_o[i])
        );
    end
    // the first beat is loaded on the halt cycle, before channel 0's last event lands
    assign first = !event_i[CH_INST] ? cnt[CH_INST] :
                   (&cnt[CH_INST]) ? (SATURATE ? cnt[CH_INST] : '0) : cnt[CH_INST] + CNT_W'(1);
    assign nxt   = idx_q + IDX_W'(1);
    always_comb begin
        sel = '0;
        for (int k = 0; k <= NUM_CH; k++)
            if (nxt == IDX_W'(k)) sel = cnt[k];
    end
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        if (clr) begin
            state_d = COUNT;
            idx_d   = '0;
            data_d  = '0;
        end else if (state_q == COUNT && en && halt_i) begin
            state_d = DUMP;
            idx_d   = '0;
            data_d  = first;
        end else if (state_q == DUMP && dump_ready_i) begin
            state_d = (idx_q == LAST) ? DONE : DUMP;
            idx_d   = (idx_q == LAST) ? idx_q : nxt;
            data_d  = (idx_q == LAST) ? data_q : sel;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COUNT;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end
    assign dump_valid_o = state_q == DUMP;
    assign done_o       = state_q == DONE;
    assign dump_idx_o   = idx_q;
    assign dump_data_o  = data_q;
    assign cycle_cnt_o  = cnt[NUM_CH];
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: randomized checks of three bank configurations against a count-based reference model
module tb_perf_counter_bank;
    import perf_pkg::*;
    localparam int N = 4;
    localparam int P_CNT = 0, P_DMP = 1, P_DONE = 2;
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, clr = 1'b0, halt_i = 1'b0, dump_ready_i = 1'b0;
    logic [N-1:0] event_i = '0;
    logic a_valid, a_done, s_valid, s_done, w_valid, w_done;
    logic [2:0] a_idx, s_idx, w_idx;
    logic [7:0] a_data, a_cyc;
    logic [3:0] s_data, s_cyc, w_data, w_cyc;
    logic [N:0] a_ovf, s_ovf, w_ovf;
    int checks = 0, failures = 0;
    int n [N+1];
    int ph, xi;

    perf_counter_bank #(.NUM_CH(N), .CNT_W(8), .SATURATE(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .event_i(event_i), .halt_i(halt_i),
        .dump_valid_o(a_valid), .dump_ready_i(dump_ready_i), .dump_idx_o(a_idx),
        .dump_data_o(a_data), .done_o(a_done), .ovf_o(a_ovf), .cycle_cnt_o(a_cyc));
    perf_counter_bank #(.NUM_CH(N), .CNT_W(4), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .event_i(event_i), .halt_i(halt_i),
        .dump_valid_o(s_valid), .dump_ready_i(dump_ready_i), .dump_idx_o(s_idx),
        .dump_data_o(s_data), .done_o(s_done), .ovf_o(s_ovf), .cycle_cnt_o(s_cyc));
    perf_counter_bank #(.NUM_CH(N), .CNT_W(4), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .event_i(event_i), .halt_i(halt_i),
        .dump_valid_o(w_valid), .dump_ready_i(dump_ready_i), .dump_idx_o(w_idx),
        .dump_data_o(w_data), .done_o(w_done), .ovf_o(w_ovf), .cycle_cnt_o(w_cyc));

    always #5 clk = ~clk;

    function automatic int mv(input int x, input int w, input bit s);
        int lim;
        lim = (1 << w) - 1;
        return s ? (x > lim ? lim : x) : x % (1 << w);
    endfunction

    function automatic logic [N:0] mo(input int w);
        logic [N:0] r;
        for (int k = 0; k <= N; k++) r[k] = n[k] > (1 << w) - 1;
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k <= N; k++) n[k] = 0;
        ph = P_CNT;
        xi = 0;
    endtask

    task automatic cycle(input logic [N-1:0] ev, input logic h, input logic r, input logic e, input logic c);
        event_i = ev; halt_i = h; dump_ready_i = r; en = e; clr = c;
        if (c) model_reset();
        else if (ph == P_CNT && e) begin
            for (int k = 0; k < N; k++) n[k] += int'(ev[k]);
            n[N]++;
            if (h) begin ph = P_DMP; xi = 0; end
        end else if (ph == P_DMP && r) begin
            if (xi == N) ph = P_DONE;
            else xi++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({a_valid, a_done, a_ovf, a_idx, a_data, a_cyc} !== '0) begin
            failures++; $display("FAIL reset_a got=%h exp=0", {a_valid, a_done, a_ovf, a_idx, a_data, a_cyc});
        end
        checks++;
        if ({s_valid, s_done, s_ovf, s_idx, s_data, s_cyc, w_valid, w_done, w_ovf, w_idx, w_data, w_cyc} !== '0) begin
            failures++; $display("FAIL reset_sw got=%h exp=0", {s_valid, s_done, s_ovf, s_data, w_valid, w_done, w_ovf, w_data});
        end
        rst_n = 1'b1;
        cycle('0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({a_valid, a_cyc} !== '0) begin
            failures++; $display("FAIL reset_idle got valid=%b cyc=%0d exp valid=0 cyc=0", a_valid, a_cyc);
        end
    endtask

    task automatic test_basic();
        logic [N-1:0] ev;
        int exp_a [N+1] = '{10, 0, 10, 0, 10};
        ev = '0; ev[CH_INST] = 1'b1; ev[CH_IHIT] = 1'b1;
        for (int i = 0; i < 10; i++) cycle(ev, i == 9, 1'b1, 1'b1, 1'b0);
        for (int b = 0; b <= N; b++) begin
            checks++;
            if ({a_valid, a_idx, a_data} !== {1'b1, 3'(b), 8'(exp_a[b])}) begin
                failures++; $display("FAIL basic_beat%0d got v=%b idx=%0d data=%0d exp v=1 idx=%0d data=%0d", b, a_valid, a_idx, a_data, b, exp_a[b]);
            end
            checks++;
            if ({s_data, w_data} !== {4'(mv(n[b], 4, 1)), 4'(mv(n[b], 4, 0))}) begin
                failures++; $display("FAIL basic_sw_beat%0d got s=%0d w=%0d exp s=%0d w=%0d", b, s_data, w_data, mv(n[b], 4, 1), mv(n[b], 4, 0));
            end
            cycle('0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        checks++;
        if ({a_done, a_valid} !== 2'b10) begin
            failures++; $display("FAIL basic_done got done=%b valid=%b exp done=1 valid=0", a_done, a_valid);
        end
    endtask

    task automatic test_overflow();
        cycle('0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) cycle(N'($urandom) | N'(1), i == 19, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({s_data, w_data, s_ovf[0], w_ovf[0], a_ovf[0]} !== {4'd15, 4'd4, 1'b1, 1'b1, 1'b0}) begin
            failures++; $display("FAIL ovf_ch0 got s=%0d w=%0d ovf s/w/a=%b%b%b exp s=15 w=4 ovf=110", s_data, w_data, s_ovf[0], w_ovf[0], a_ovf[0]);
        end
        checks++;
        if ({a_ovf, s_ovf, w_ovf} !== {mo(8), mo(4), mo(4)}) begin
            failures++; $display("FAIL ovf_flags got a=%b s=%b w=%b exp a=%b sw=%b", a_ovf, s_ovf, w_ovf, mo(8), mo(4));
        end
        for (int b = 0; b <= N; b++) begin
            checks++;
            if ({a_data, s_data, w_data} !== {8'(mv(n[b], 8, 0)), 4'(mv(n[b], 4, 1)), 4'(mv(n[b], 4, 0))}) begin
                failures++; $display("FAIL ovf_beat%0d got a=%0d s=%0d w=%0d exp a=%0d s=%0d w=%0d", b, a_data, s_data, w_data, mv(n[b], 8, 0), mv(n[b], 4, 1), mv(n[b], 4, 0));
            end
            cycle('0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
    endtask

    task automatic test_backpressure();
        int len;
        logic [7:0] hold;
        cycle('0, 1'b0, 1'b1, 1'b1, 1'b1);
        len = $urandom_range(3, 12);
        for (int i = 0; i < len; i++) cycle(N'($urandom), i == len - 1, 1'b1, i == len - 1 || $urandom_range(0, 3) != 0, 1'b0);
        for (int b = 0; b < 2; b++) cycle(N'($urandom), 1'b1, 1'b1, 1'b1, 1'b0);
        hold = a_data;
        checks++;
        if ({a_valid, a_idx, a_data} !== {1'b1, 3'd2, 8'(mv(n[2], 8, 0))}) begin
            failures++; $display("FAIL bp_entry got v=%b idx=%0d data=%0d exp v=1 idx=2 data=%0d", a_valid, a_idx, a_data, mv(n[2], 8, 0));
        end
        for (int i = 0; i < 3; i++) begin
            cycle(N'($urandom), 1'b1, 1'b0, 1'b1, 1'b0);
            checks++;
            if ({a_valid, a_idx, a_data} !== {1'b1, 3'd2, hold}) begin
                failures++; $display("FAIL bp_hold%0d got v=%b idx=%0d data=%0d exp v=1 idx=2 data=%0d", i, a_valid, a_idx, a_data, hold);
            end
        end
        for (int b = 3; b <= N; b++) begin
            cycle('0, 1'b0, 1'b1, 1'b1, 1'b0);
            checks++;
            if ({a_valid, a_idx, a_data, s_data} !== {1'b1, 3'(b), 8'(mv(n[b], 8, 0)), 4'(mv(n[b], 4, 1))}) begin
                failures++; $display("FAIL bp_beat%0d got v=%b idx=%0d data=%0d s=%0d exp idx=%0d data=%0d s=%0d", b, a_valid, a_idx, a_data, s_data, b, mv(n[b], 8, 0), mv(n[b], 4, 1));
            end
        end
        cycle('0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({a_valid, a_done} !== 2'b01) begin
            failures++; $display("FAIL bp_done got valid=%b done=%b exp valid=0 done=1", a_valid, a_done);
        end
    endtask

    task automatic test_clr();
        logic [N-1:0] ev;
        ev = '0; ev[CH_INST] = 1'b1; ev[CH_DREQ] = 1'b1;
        cycle('0, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (3) cycle(ev, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(ev, 1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({a_cyc, a_ovf, a_valid} !== '0) begin
            failures++; $display("FAIL clr_event got cyc=%0d ovf=%b valid=%b exp 0", a_cyc, a_ovf, a_valid);
        end
        cycle('0, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({a_valid, a_idx, a_data, a_cyc} !== {1'b1, 3'd0, 8'd0, 8'd1} || n[0] != 0) begin
            failures++; $display("FAIL clr_ch0 got v=%b idx=%0d data=%0d cyc=%0d exp v=1 idx=0 data=0 cyc=1", a_valid, a_idx, a_data, a_cyc);
        end
        cycle('0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(N'($urandom), 1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({a_valid, a_done, a_cyc, a_ovf, s_ovf, w_ovf} !== '0) begin
            failures++; $display("FAIL clr_dump got valid=%b done=%b cyc=%0d exp 0", a_valid, a_done, a_cyc);
        end
        cycle(ev, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({a_valid, a_cyc} !== {1'b0, 8'd1}) begin
            failures++; $display("FAIL clr_dump_resume got valid=%b cyc=%0d exp valid=0 cyc=1", a_valid, a_cyc);
        end
        cycle('0, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (N + 1) cycle('0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(N'($urandom), 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({a_done, a_valid, a_cyc} !== {1'b1, 1'b0, 8'(mv(n[N], 8, 0))}) begin
            failures++; $display("FAIL done_frozen got done=%b valid=%b cyc=%0d exp done=1 valid=0 cyc=%0d", a_done, a_valid, a_cyc, mv(n[N], 8, 0));
        end
        cycle(ev, 1'b0, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({a_done, a_cyc} !== '0) begin
            failures++; $display("FAIL clr_done got done=%b cyc=%0d exp done=0 cyc=0", a_done, a_cyc);
        end
        cycle(ev, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (a_cyc !== 8'd1) begin
            failures++; $display("FAIL clr_done_resume got cyc=%0d exp 1", a_cyc);
        end
    endtask

    task automatic test_en_gating();
        cycle('0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(N'($urandom) | N'(1 << CH_IREQ), 1'b1, 1'b1, 1'b0, 1'b0);
            checks++;
            if ({a_valid, a_done, a_cyc, s_cyc, w_cyc} !== '0) begin
                failures++; $display("FAIL en_gate%0d got valid=%b done=%b cyc=%0d exp 0", i, a_valid, a_done, a_cyc);
            end
        end
        cycle('0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int b = 0; b <= N; b++) begin
            checks++;
            if ({a_valid, a_idx, a_data} !== {1'b1, 3'(b), (b == N) ? 8'd1 : 8'd0} || mv(n[b], 8, 0) != ((b == N) ? 1 : 0)) begin
                failures++; $display("FAIL en_beat%0d got v=%b idx=%0d data=%0d exp v=1 idx=%0d data=%0d", b, a_valid, a_idx, a_data, b, (b == N) ? 1 : 0);
            end
            cycle('0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
    endtask

    task automatic test_random();
        cycle('0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 400; i++) begin
            cycle(N'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) != 0, $urandom_range(0, 63) == 0);
            checks++;
            if ({a_valid, a_done, a_ovf, a_cyc} !== {ph == P_DMP, ph == P_DONE, mo(8), 8'(mv(n[N], 8, 0))}) begin
                failures++; $display("FAIL rand_a_state%0d got v=%b d=%b ovf=%b cyc=%0d exp ph=%0d ovf=%b cyc=%0d", i, a_valid, a_done, a_ovf, a_cyc, ph, mo(8), mv(n[N], 8, 0));
            end
            checks++;
            if ({s_valid, s_done, s_ovf, s_cyc, w_valid, w_done, w_ovf, w_cyc} !==
                {ph == P_DMP, ph == P_DONE, mo(4), 4'(mv(n[N], 4, 1)), ph == P_DMP, ph == P_DONE, mo(4), 4'(mv(n[N], 4, 0))}) begin
                failures++; $display("FAIL rand_sw_state%0d got s ovf=%b cyc=%0d w ovf=%b cyc=%0d exp ph=%0d ovf=%b", i, s_ovf, s_cyc, w_ovf, w_cyc, ph, mo(4));
            end
            if (ph == P_DMP) begin
                checks++;
                if ({a_idx, a_data, s_idx, s_data, w_idx, w_data} !== {3'(xi), 8'(mv(n[xi], 8, 0)), 3'(xi), 4'(mv(n[xi], 4, 1)), 3'(xi), 4'(mv(n[xi], 4, 0))}) begin
                    failures++; $display("FAIL rand_beat%0d got idx=%0d a=%0d s=%0d w=%0d exp idx=%0d a=%0d s=%0d w=%0d", i, a_idx, a_data, s_data, w_data, xi, mv(n[xi], 8, 0), mv(n[xi], 4, 1), mv(n[xi], 4, 0));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        cycle('0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) cycle(N'($urandom), i == 19, 1'b1, 1'b1, 1'b0);
        cycle('0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({a_valid, a_idx, s_ovf} !== {1'b1, 3'd1, mo(4)}) begin
            failures++; $display("FAIL arst_pre got v=%b idx=%0d ovf=%b exp v=1 idx=1 ovf=%b", a_valid, a_idx, s_ovf, mo(4));
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_valid, a_done, a_ovf, s_valid, s_ovf, w_ovf, a_cyc} !== '0) begin
            failures++; $display("FAIL arst_immediate got valid=%b done=%b ovf a/s/w=%b/%b/%b cyc=%0d exp 0", a_valid, a_done, a_ovf, s_ovf, w_ovf, a_cyc);
        end
        model_reset();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) cycle(N'($urandom), 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({a_valid, a_done, a_cyc} !== {1'b0, 1'b0, 8'd6}) begin
            failures++; $display("FAIL arst_restart got valid=%b done=%b cyc=%0d exp valid=0 done=0 cyc=6", a_valid, a_done, a_cyc);
        end
        cycle('0, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({a_valid, a_idx, a_data} !== {1'b1, 3'd0, 8'(mv(n[0], 8, 0))}) begin
            failures++; $display("FAIL arst_dump got v=%b idx=%0d data=%0d exp v=1 idx=0 data=%0d", a_valid, a_idx, a_data, mv(n[0], 8, 0));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_clr();
        test_en_gating();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
